// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state encoding, default widths and FIFO entry layout for the note sequencer.
package note_seq_pkg;
    localparam int FREQ_W_DEF = 32;
    localparam int DUR_W_DEF  = 16;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    typedef struct packed {
        logic [FREQ_W_DEF-1:0] freq;
        logic [DUR_W_DEF-1:0]  dur;
    } entry_t;
endpackage

// File: rtl/note_fifo.sv
// note_fifo: synchronous FIFO with push/pop/flush, occupancy level and a sticky drop flag.
module note_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_pop  = pop && !empty;
    // a simultaneous pop frees a slot, so a full FIFO still accepts the write
    assign do_push = push && (!full || do_pop);
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays queued {freq, dur} notes into the Notas generator, one tick = TICK_DIV clks.
// Define NOTE_GAP_EN to insert a GAP_TICKS silent gap after every note.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int FREQ_W    = FREQ_W_DEF,
    parameter int DUR_W     = DUR_W_DEF,
    parameter int DEPTH     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [FREQ_W-1:0]      wr_freq,
    input  logic [DUR_W-1:0]       wr_dur,
    input  logic                   play,
    input  logic                   abort,
    output logic [FREQ_W-1:0]      freq,
    output logic                   stop,
    output logic                   busy,
    output logic                   note_done,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int PW = $clog2(TICK_DIV + 1);
`ifdef NOTE_GAP_EN
    localparam bit GAP_BUILD = 1'b1;
`else
    localparam bit GAP_BUILD = 1'b0;
`endif
    localparam bit GAP_ON = GAP_BUILD && (GAP_TICKS > 0);

    state_t                  state, next;
    logic [FREQ_W+DUR_W-1:0] head;
    logic [FREQ_W-1:0]       cur_freq;
    logic [DUR_W-1:0]        cur_dur, dur_cnt;
    logic [PW-1:0]           presc;
    logic                    fetch, pop, note_end, tick;
`ifdef NOTE_GAP_EN
    logic [15:0]             gap_cnt;
`endif

    note_fifo #(.WIDTH(FREQ_W + DUR_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(wr_en), .pop(pop), .flush(abort),
        .din({wr_freq, wr_dur}), .dout(head), .level(level),
        .full(full), .empty(empty), .overflow(overflow)
    );

    assign fetch = play && !empty;
    assign tick  = presc == PW'(TICK_DIV - 1);
    assign busy  = state != IDLE;

    always_comb begin
        next     = state;
        pop      = 1'b0;
        note_end = 1'b0;
        case (state)
            IDLE: begin
                pop  = fetch;
                next = fetch ? LOAD : IDLE;
            end
            LOAD: next = PLAY;
            PLAY: if (tick && dur_cnt == DUR_W'(1)) begin
                note_end = 1'b1;
                pop      = !GAP_ON && fetch;
                next     = GAP_ON ? GAP : fetch ? LOAD : IDLE;
            end
`ifdef NOTE_GAP_EN
            GAP: if (tick && gap_cnt == 16'd1) begin
                pop  = fetch;
                next = fetch ? LOAD : IDLE;
            end
`endif
            default: next = IDLE;
        endcase
        if (abort) begin
            next     = IDLE;
            pop      = 1'b0;
            note_end = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            freq      <= '0;
            stop      <= 1'b1;
            note_done <= 1'b0;
            presc     <= '0;
            dur_cnt   <= '0;
            cur_freq  <= '0;
            cur_dur   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            freq      <= '0;
            stop      <= 1'b1;
            note_done <= 1'b0;
            presc     <= '0;
        end else begin
            state     <= next;
            note_done <= note_end;
            if (pop) {cur_freq, cur_dur} <= head;
            // the LOAD cycle keeps stop high so Notas always restarts its count cleanly
            if (state == LOAD) begin
                freq    <= cur_freq;
                stop    <= cur_freq == '0;
                dur_cnt <= cur_dur == '0 ? DUR_W'(1) : cur_dur;
                presc   <= '0;
            end else if (state == PLAY || state == GAP) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            if (note_end) stop <= 1'b1;
            else if (state == PLAY && tick) dur_cnt <= dur_cnt - 1'b1;
        end
    end

`ifdef NOTE_GAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) gap_cnt <= '0;
        else if (note_end) gap_cnt <= 16'(GAP_TICKS);
        else if (state == GAP && tick) gap_cnt <= gap_cnt - 1'b1;
    end
`endif
endmodule
